// File: rtl/mac_pkg.sv
// Shared constants for the MAC array datapath and its output collector.
package mac_pkg;

    localparam int PSUM_BW     = 16;
    localparam int COL         = 8;
    localparam int OFIFO_DEPTH = 64;

    // Pointer carries one extra wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_col.sv
// Single-column synchronous FIFO with a wrap-bit pointer pair and a drop indication.
module fifo_col
    import mac_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               wr,
    input  logic               rd,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               drop
);

    localparam int PW = ptr_w(depth);
    localparam int AW = PW - 1;

    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [psum_bw-1:0] mem_q [depth];
    logic               wr_en;
    logic               rd_en;

    always_comb begin
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        wr_en  = wr & ~full;
        rd_en  = rd & ~empty;
        drop   = wr & full;
        wptr_d = wr_en ? wptr_q + PW'(1) : wptr_q;
        rptr_d = rd_en ? rptr_q + PW'(1) : rptr_q;
        dout   = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mac_ofifo.sv
// South-edge psum collector: per-column queues absorb valid skew, rows pop together.
module mac_ofifo
    import mac_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_strobe,
    output logic [col-1:0]         overflow
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         drop;
    logic [psum_bw*col-1:0] row;
    logic                   rd_acc;

    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   strobe_q, strobe_d;
    logic [col-1:0]         ovf_q, ovf_d;

    for (genvar g = 0; g < col; g++) begin : g_col
        fifo_col #(
            .psum_bw(psum_bw),
            .depth  (depth)
        ) u_fifo (
            .clk  (clk),
            .reset(reset),
            .din  (in[psum_bw*g +: psum_bw]),
            .wr   (wr[g]),
            .rd   (rd_acc),
            .dout (row[psum_bw*g +: psum_bw]),
            .empty(empty[g]),
            .full (full[g]),
            .drop (drop[g])
        );
    end

    always_comb begin
        o_valid  = &(~empty);
        o_full   = |full;
        o_ready  = ~o_full;
        rd_acc   = rd & o_valid;
        out_d    = rd_acc ? row : out_q;
        strobe_d = rd_acc;
        ovf_d    = ovf_q | drop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q    <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            out_q    <= out_d;
            strobe_q <= strobe_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out        = out_q;
    assign out_strobe = strobe_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mac_ofifo.sv
// Directed bench for mac_ofifo: vector table for the skewed-row pop sequence plus a row scoreboard.
module tb_mac_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int W     = COL * BW;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   in_v = '0;
    logic [COL-1:0] wr = '0;
    logic           rd = 1'b0;
    logic           o_valid, o_ready, o_full, out_strobe;
    logic [W-1:0]   out;
    logic [COL-1:0] overflow;

    mac_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in(in_v), .wr(wr), .rd(rd),
        .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full),
        .out(out), .out_strobe(out_strobe), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0]   q[$];
    logic [W-1:0]   last_out = '0;
    logic [COL-1:0] exp_ovf = '0;

    typedef struct {
        logic         rd;
        logic         exp_valid;
        logic         exp_strobe;
        logic [W-1:0] exp_out;
    } vec_t;
    vec_t tv[6];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] skew_row(input int k);
        logic [W-1:0] r;
        for (int c = 0; c < COL; c++) r[BW*c +: BW] = 16'(256 * c + k);
        return r;
    endfunction

    function automatic logic [W-1:0] gen_row(input int k, input int salt);
        logic [W-1:0] r;
        for (int c = 0; c < COL; c++) r[BW*c +: BW] = 16'(k * 37 + c * 4099 + salt);
        return r;
    endfunction

    task automatic skew_fill(input int nrows);
        for (int t = 0; t < nrows + 7; t++) begin
            wr = '0;
            for (int c = 0; c < COL; c++) begin
                if (t - c >= 0 && t - c < nrows) begin
                    wr[c] = 1'b1;
                    in_v[BW*c +: BW] = 16'(256 * c + (t - c));
                end
            end
            step();
            chk("skew_valid", W'(o_valid), W'(t >= 7));
        end
        wr = '0;
    endtask

    // One clock of aligned traffic, checked against the row scoreboard.
    task automatic do_cyc(input logic [COL-1:0] mask, input logic [W-1:0] row, input logic rd_i);
        bit can_rd;
        bit is_full;
        can_rd  = (q.size() > 0);
        is_full = (q.size() == DEPTH);
        wr = mask;
        in_v = row;
        rd = rd_i;
        step();
        if (rd_i && can_rd) begin
            last_out = q.pop_front();
            chk("strobe", W'(out_strobe), W'(1));
        end else begin
            chk("strobe", W'(out_strobe), W'(0));
        end
        chk("out", out, last_out);
        if (mask != '0) begin
            if (is_full) exp_ovf |= mask;
            else q.push_back(row);
        end
        chk("overflow", W'(overflow), W'(exp_ovf));
        chk("o_valid", W'(o_valid), W'(q.size() > 0));
        chk("o_full", W'(o_full), W'(q.size() == DEPTH));
        chk("o_ready", W'(o_ready), W'(q.size() != DEPTH));
        wr = '0;
        rd = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, W'(o_valid), W'(0));
        chk({tag, "_ready"}, W'(o_ready), W'(1));
        chk({tag, "_full"}, W'(o_full), W'(0));
        chk({tag, "_out"}, out, '0);
        chk({tag, "_strobe"}, W'(out_strobe), W'(0));
        chk({tag, "_ovf"}, W'(overflow), W'(0));
    endtask

    initial begin
        int wrote;
        int nread;
        int cyc;
        bit w, r;

        tv[0] = '{1'b1, 1'b1, 1'b1, skew_row(0)};
        tv[1] = '{1'b0, 1'b1, 1'b0, skew_row(0)};
        tv[2] = '{1'b1, 1'b1, 1'b1, skew_row(1)};
        tv[3] = '{1'b1, 1'b1, 1'b1, skew_row(2)};
        tv[4] = '{1'b1, 1'b0, 1'b1, skew_row(3)};
        tv[5] = '{1'b1, 1'b0, 1'b0, skew_row(3)};

        #12;
        chk_reset_state("init");
        reset = 1'b1;

        skew_fill(4);
        foreach (tv[i]) begin
            rd = tv[i].rd;
            step();
            chk("tv_valid", W'(o_valid), W'(tv[i].exp_valid));
            chk("tv_strobe", W'(out_strobe), W'(tv[i].exp_strobe));
            chk("tv_out", out, tv[i].exp_out);
        end
        rd = 1'b0;

        skew_fill(5);
        #2 reset = 1'b0;
        #1 chk_reset_state("midrst");
        #2 reset = 1'b1;
        q.delete();
        last_out = '0;
        exp_ovf = '0;
        do_cyc('1, gen_row(0, 16'hA5A5), 1'b0);
        do_cyc('0, '0, 1'b1);

        for (int k = 0; k < DEPTH; k++) do_cyc('1, gen_row(k, 1), 1'b0);
        do_cyc(8'h08, gen_row(99, 1), 1'b0);
        chk("ovf_col3", W'(overflow), W'(8'h08));
        for (int k = 0; k < DEPTH; k++) do_cyc('0, '0, 1'b1);
        do_cyc('0, '0, 1'b1);

        do_cyc('1, gen_row(0, 7), 1'b0);
        wrote = 1;
        nread = 0;
        cyc = 0;
        while ((wrote < 200 || q.size() > 0) && cyc < 5000) begin
            w = (wrote < 200) && (q.size() < 10) && (($urandom_range(0, 1) == 1) || q.size() <= 1);
            r = ((q.size() >= 2) && ($urandom_range(0, 1) == 1)) || (wrote == 200 && q.size() > 0);
            if (r) nread++;
            do_cyc(w ? '1 : '0, gen_row(wrote, 7), r);
            if (w) wrote++;
            cyc++;
        end
        chk("wrap_reads", W'(nread), W'(200));
        chk("wrap_empty", W'(q.size()), W'(0));

        for (int k = 0; k < 3; k++) do_cyc('1, gen_row(k, 3), 1'b0);
        for (int k = 3; k < 23; k++) do_cyc('1, gen_row(k, 3), 1'b1);
        chk("steady_occ", W'(q.size()), W'(3));
        for (int k = 0; k < 3; k++) do_cyc('0, '0, 1'b1);

        for (int k = 0; k < DEPTH; k++) do_cyc('1, gen_row(k, 11), 1'b0);
        do_cyc('1, gen_row(500, 11), 1'b1);
        chk("fullrw_ovf", W'(overflow), W'(8'hFF));
        chk("fullrw_occ", W'(q.size()), W'(63));
        for (int k = 0; k < 63; k++) do_cyc('0, '0, 1'b1);
        do_cyc('0, '0, 1'b1);

        #2 reset = 1'b0;
        #1 chk_reset_state("endrst");
        #2 reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_ofifo.md
Name: mac_ofifo

Overview:
- Output collector on the south edge of the systolic MAC array.
- Captures each column's partial sum when that column's valid pulses. Valids arrive skewed by one cycle per column, so each column is queued independently.
- Presents complete, column-aligned rows of psums to the downstream reader (SFU / SRAM writeback) through a rd/strobe handshake.

Parameters:
col, 8, number of array columns (independent column queues)
psum_bw, 16, width of one partial sum
depth, 64, entries per column queue; power of two, >= 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
in  input  psum_bw*col  psums from array south edge; column c at bits [psum_bw*(c+1)-1 : psum_bw*c]
wr  input  col  per-column write strobe, driven by array valid[c]
rd  input  1  reader requests pop of one full row
o_valid  output  1  every column queue non-empty (a full row is available)
o_ready  output  1  no column queue full
o_full  output  1  at least one column queue full (equals ~o_ready)
out  output  psum_bw*col  last popped row, registered; same column packing as in
out_strobe  output  1  one-cycle pulse: out updated this cycle
overflow  output  col  sticky per-column flag: a write was dropped because the queue was full

Behaviour:
- Reset (reset=0, asynchronous): all read/write pointers 0; out=0; out_strobe=0; overflow=0.
  - Resulting flag values: o_valid=0, o_ready=1, o_full=0.
  - Queue storage is not reset.
- Reset released mid-traffic: all in-flight data is discarded. Writes are accepted from the first rising edge with reset=1.
- Each column queue holds a write pointer and a read pointer, each log2(depth)+1 bits.
  - Empty: pointers equal.
  - Full: low bits equal and MSB differs.
  - Pointers wrap modulo 2*depth. Storage is indexed by the low log2(depth) bits.
- Write, per column c independently:
  - Condition: wr[c]=1 and queue c not full, with fullness sampled before the edge.
  - Action: store in slice c at wptr[c], then increment wptr[c].
  - wr[c]=1 while queue c is full: data dropped, pointers unchanged, overflow[c] set to 1 on that edge. It stays 1 until reset.
  - A full queue that is also popped in the same cycle still drops the write; no write-through on full.
- Read:
  - Accepted when rd=1 and o_valid=1, both sampled before the edge.
  - On acceptance, all col read pointers increment together.
  - The row at the old read pointers is registered into out on the same edge, and out_strobe=1 for the following cycle.
  - Read latency: out and out_strobe are valid one cycle after the accepting edge.
  - rd=1 while o_valid=0: ignored; no pointer change, out holds, out_strobe=0.
  - Back-to-back reads allowed every cycle while o_valid stays 1.
- Simultaneous write and read on a non-full, non-empty queue: both take effect and occupancy is unchanged.
  - An empty queue cannot be read, because o_valid requires all columns non-empty before the edge. A row written in cycle t is poppable at t+1 at the earliest.
- Flags o_valid, o_ready and o_full are combinational from the pointers (current state); they update the cycle after the edge that changed the pointers.
- out holds its last popped value when no read is accepted.
- Data is passed unmodified: no arithmetic, no sign handling; psum_bw bits per column, bit-exact.

Decomposition:
- Shared package mac_pkg: constants PSUM_BW=16, COL=8, OFIFO_DEPTH=64, and a helper for the pointer width (log2(depth)+1).
- Sub-module fifo_col: single-column synchronous FIFO.
  - Ports: clk, reset, din, wr, rd, dout, empty, full, drop.
  - Instantiated col times in a generate loop.
- Top level contains:
  - o_valid = AND of ~empty
  - o_full = OR of full
  - a common rd gated by o_valid
  - the out/out_strobe registers
  - the overflow sticky bits

Test Plan:
- Reset check: drive reset=0 mid-stream after 5 skewed rows are queued, release reset -> o_valid=0, o_ready=1, out=0, overflow=0. A fresh row written afterwards pops as the first row.
- Skewed fill: write row k (each column's value = 16'h0100*c + k) with wr[c] asserted at cycle k+c, for k=0..3 -> o_valid rises only after column 7's first write. Four reads return rows 0..3 in order with exact values, out_strobe one cycle after each accepted rd.
- Full/overflow: write 64 rows to all columns, then one more with wr[3]=1 only -> o_full=1, o_ready=0, overflow=8'b0000_1000. Popping 64 rows returns rows 0..63 only. A subsequent rd with o_valid=0 -> out_strobe=0 and out unchanged.
- Wrap-around: perform 200 interleaved writes and reads at occupancy between 1 and 10 -> pointers wrap past 2*depth with no lost or duplicated rows. A scoreboard matches all 200 rows.
- Simultaneous rd and wr at steady occupancy of 3 for 20 cycles -> o_valid stays 1, occupancy stays 3, out sequence is in order.
- Write to a full queue concurrent with a read of that queue -> the read succeeds, the write is dropped, overflow for that column is set, and occupancy is 63 afterwards.
